// File: rtl/slc3_fetch_ctrl_pkg.sv
// Shared types and constants for the SLC-3 fetch controller.
package slc3_fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        HALTED = 3'd0,
        FETCH1 = 3'd1,
        MEM_RD = 3'd2,
        FETCH3 = 3'd3,
        PAUSE  = 3'd4
    } ctrl_state_t;

    localparam int unsigned MEM_WAIT_DEFAULT = 2;
    // Wide enough for MEM_WAIT up to 15.
    localparam int unsigned WAIT_W = 4;

endpackage

// File: rtl/slc3_fetch_ctrl_if.sv
// Operator buttons in; datapath load/gate enables, SRAM strobes and debug status out.
interface slc3_fetch_ctrl_if
    import slc3_fetch_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
);
    logic             Run;
    logic             Continue;
    logic             load_mar;
    logic             load_pc;
    logic             load_mdr;
    logic             load_ir;
    logic             gate_pc;
    logic             gate_mdr;
    logic             mio_en;
    logic             CE;
    logic             UB;
    logic             LB;
    logic             OE;
    logic             WE;
    ctrl_state_t      state_dbg;
    logic [CNT_W-1:0] inst_count;

    modport master (
        input  Run, Continue,
        output load_mar, load_pc, load_mdr, load_ir, gate_pc, gate_mdr, mio_en,
        output CE, UB, LB, OE, WE, state_dbg, inst_count
    );

    modport slave (
        output Run, Continue,
        input  load_mar, load_pc, load_mdr, load_ir, gate_pc, gate_mdr, mio_en,
        input  CE, UB, LB, OE, WE, state_dbg, inst_count
    );
endinterface

// File: rtl/slc3_fetch_ctrl_button_press.sv
// Turns an active-low, pre-debounced button level into a one-cycle press pulse.
module slc3_fetch_ctrl_button_press (
    input  logic Clk,
    input  logic Reset,
    input  logic btn,
    output logic press
);
    logic prev_q;
    logic armed_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            prev_q  <= 1'b1;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= btn;
            armed_q <= 1'b1;
        end
    end

    // armed_q masks the first edge after reset so a button already held through
    // reset release is not mistaken for a fresh press.
    assign press = armed_q & prev_q & ~btn;

endmodule

// File: rtl/slc3_fetch_ctrl.sv
// Fetch-loop sequencer for the SLC-3: MAR<-PC, MDR<-M[MAR], IR<-MDR, then pause.
module slc3_fetch_ctrl
    import slc3_fetch_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = MEM_WAIT_DEFAULT,
    parameter int unsigned CNT_W    = 16
) (
    input logic                Clk,
    input logic                Reset,
    slc3_fetch_ctrl_if.master  bus
);
    localparam logic [WAIT_W-1:0] WaitLast = WAIT_W'(MEM_WAIT - 1);

    logic              run_press;
    logic              cont_press;
    logic              mem_last;
    ctrl_state_t       state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    slc3_fetch_ctrl_button_press u_run (
        .Clk   (Clk),
        .Reset (Reset),
        .btn   (bus.Run),
        .press (run_press)
    );

    slc3_fetch_ctrl_button_press u_cont (
        .Clk   (Clk),
        .Reset (Reset),
        .btn   (bus.Continue),
        .press (cont_press)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= HALTED;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_last = (wait_q == WaitLast);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        cnt_d   = cnt_q;
        case (state_q)
            HALTED: if (run_press) state_d = FETCH1;
            FETCH1: begin
                wait_d  = '0;
                state_d = MEM_RD;
            end
            MEM_RD: begin
                wait_d = wait_q + WAIT_W'(1);
                if (mem_last) state_d = FETCH3;
            end
            FETCH3: begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = PAUSE;
            end
            PAUSE:  if (cont_press) state_d = FETCH1;
            default: state_d = HALTED;
        endcase
    end

    // Outputs depend only on registered state, so async reset idles them at once.
    always_comb begin
        bus.load_mar   = 1'b0;
        bus.load_pc    = 1'b0;
        bus.load_mdr   = 1'b0;
        bus.load_ir    = 1'b0;
        bus.gate_pc    = 1'b0;
        bus.gate_mdr   = 1'b0;
        bus.mio_en     = 1'b0;
        bus.CE         = 1'b1;
        bus.UB         = 1'b1;
        bus.LB         = 1'b1;
        bus.OE         = 1'b1;
        bus.WE         = 1'b1;
        bus.state_dbg  = state_q;
        bus.inst_count = cnt_q;
        case (state_q)
            FETCH1: begin
                bus.gate_pc  = 1'b1;
                bus.load_mar = 1'b1;
                bus.load_pc  = 1'b1;
            end
            MEM_RD: begin
                bus.CE       = 1'b0;
                bus.UB       = 1'b0;
                bus.LB       = 1'b0;
                bus.OE       = 1'b0;
                bus.mio_en   = 1'b1;
                bus.load_mdr = mem_last;
            end
            FETCH3: begin
                bus.gate_mdr = 1'b1;
                bus.load_ir  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_slc3_fetch_ctrl.sv
// Scoreboard bench: per-cycle expected control vectors queued at each button press.
module tb_slc3_fetch_ctrl;
    import slc3_fetch_ctrl_pkg::*;

    typedef struct packed {
        logic [2:0]  st;
        logic [6:0]  ctl;   // gate_pc load_mar load_pc mio_en load_mdr gate_mdr load_ir
        logic [4:0]  strb;  // CE UB LB OE WE
        logic [15:0] cnt;
    } obs_t;

    logic Clk;
    logic Reset;
    int   vectors;
    int   miscompares;
    int   cur_dut;
    int   oe_low;
    obs_t rest;
    obs_t exp_q[$];

    slc3_fetch_ctrl_if #(.CNT_W(16)) bus_a ();
    slc3_fetch_ctrl_if #(.CNT_W(16)) bus_b ();
    slc3_fetch_ctrl_if #(.CNT_W(16)) bus_c ();

    slc3_fetch_ctrl #(.MEM_WAIT(2), .CNT_W(16)) dut_a (.Clk(Clk), .Reset(Reset), .bus(bus_a));
    slc3_fetch_ctrl #(.MEM_WAIT(1), .CNT_W(16)) dut_b (.Clk(Clk), .Reset(Reset), .bus(bus_b));
    slc3_fetch_ctrl #(.MEM_WAIT(5), .CNT_W(16)) dut_c (.Clk(Clk), .Reset(Reset), .bus(bus_c));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic obs_t mk(input logic [2:0] st, input logic [6:0] ctl,
                                input logic [4:0] s, input logic [15:0] c);
        obs_t o;
        o.st = st; o.ctl = ctl; o.strb = s; o.cnt = c;
        return o;
    endfunction

    function automatic obs_t idle(input logic [2:0] st, input logic [15:0] c);
        return mk(st, 7'b0000000, 5'b11111, c);
    endfunction

    function automatic obs_t get_obs(input int d);
        case (d)
            1: return mk(bus_b.state_dbg, {bus_b.gate_pc, bus_b.load_mar, bus_b.load_pc,
                         bus_b.mio_en, bus_b.load_mdr, bus_b.gate_mdr, bus_b.load_ir},
                         {bus_b.CE, bus_b.UB, bus_b.LB, bus_b.OE, bus_b.WE}, bus_b.inst_count);
            2: return mk(bus_c.state_dbg, {bus_c.gate_pc, bus_c.load_mar, bus_c.load_pc,
                         bus_c.mio_en, bus_c.load_mdr, bus_c.gate_mdr, bus_c.load_ir},
                         {bus_c.CE, bus_c.UB, bus_c.LB, bus_c.OE, bus_c.WE}, bus_c.inst_count);
            default: return mk(bus_a.state_dbg, {bus_a.gate_pc, bus_a.load_mar, bus_a.load_pc,
                         bus_a.mio_en, bus_a.load_mdr, bus_a.gate_mdr, bus_a.load_ir},
                         {bus_a.CE, bus_a.UB, bus_a.LB, bus_a.OE, bus_a.WE}, bus_a.inst_count);
        endcase
    endfunction

    // Expected cycles from the FETCH1 entry edge through the first PAUSE cycle.
    task automatic push_fetch(input int mw, input logic [15:0] c);
        exp_q.push_back(mk(FETCH1, 7'b1110000, 5'b11111, c));
        for (int i = 0; i < mw; i++)
            exp_q.push_back(mk(MEM_RD, {3'b000, 1'b1, (i == mw - 1), 2'b00}, 5'b00001, c));
        exp_q.push_back(mk(FETCH3, 7'b0000011, 5'b11111, c));
        exp_q.push_back(idle(PAUSE, c + 16'd1));
    endtask

    task automatic step(input int n, input string name);
        obs_t o, e;
        for (int k = 0; k < n; k++) begin
            @(posedge Clk);
            #1;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : rest;
            o = get_obs(cur_dut);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL %s cyc%0d: got %h want %h", name, k, o, e);
            end
            if (o.strb[1] === 1'b0) oe_low++;
            for (int d = 0; d < 3; d++) begin
                o = get_obs(d);
                vectors++;
                if (((o.ctl[6] & o.ctl[1]) !== 1'b0) || (o.strb[0] !== 1'b1)) begin
                    miscompares++;
                    $display("FAIL invariant dut%0d %s: got gates=%b%b WE=%b want excl, WE=1",
                             d, name, o.ctl[6], o.ctl[1], o.strb[0]);
                end
            end
        end
    endtask

    task automatic test_reset;
        cur_dut = 0;
        rest = idle(HALTED, 16'd0);
        bus_a.Run = 1'b0; bus_b.Run = 1'b0; bus_c.Run = 1'b0;
        #2 Reset = 1'b0;
        step(3, "reset_hold");
        Reset = 1'b1;
        step(3, "reset_release_run_low");
        bus_a.Run = 1'b1; bus_b.Run = 1'b1; bus_c.Run = 1'b1;
        step(2, "reset_idle");
    endtask

    task automatic test_fetch_timing;
        cur_dut = 0;
        bus_a.Run = 1'b0;
        push_fetch(2, 16'd0);
        rest = idle(PAUSE, 16'd1);
        step(7, "fetch_timing");
        bus_a.Run = 1'b1;
        step(1, "fetch_pause");
    endtask

    task automatic test_held_continue;
        cur_dut = 0;
        bus_a.Continue = 1'b0;
        push_fetch(2, 16'd1);
        rest = idle(PAUSE, 16'd2);
        step(20, "held_continue");
        bus_a.Continue = 1'b1;
        step(2, "held_release");
        bus_a.Continue = 1'b0;
        push_fetch(2, 16'd2);
        rest = idle(PAUSE, 16'd3);
        step(6, "continue_again");
        bus_a.Continue = 1'b1;
        step(1, "continue_again_rel");
    endtask

    task automatic test_dropped_presses;
        cur_dut = 0;
        bus_a.Continue = 1'b0;
        push_fetch(2, 16'd3);
        rest = idle(PAUSE, 16'd4);
        step(2, "drop_fetch1");
        bus_a.Continue = 1'b1;
        step(1, "drop_memrd0");
        bus_a.Continue = 1'b0;
        step(1, "drop_cont_in_memrd");
        bus_a.Continue = 1'b1;
        step(2, "drop_finish");
        bus_a.Run = 1'b0;
        step(3, "drop_run_in_pause");
        bus_a.Run = 1'b1;
        step(2, "drop_after");
    endtask

    task automatic test_reset_mid_read;
        obs_t o, e;
        cur_dut = 0;
        bus_a.Continue = 1'b0;
        push_fetch(2, 16'd4);
        step(2, "midrd_pre");
        bus_a.Continue = 1'b1;
        @(posedge Clk);
        #2;
        e = exp_q.pop_front();
        o = get_obs(0);
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL midrd_second: got %h want %h", o, e);
        end
        Reset = 1'b0;
        #1;
        e = idle(HALTED, 16'd0);
        o = get_obs(0);
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL midrd_async_reset: got %h want %h", o, e);
        end
        exp_q.delete();
        rest = idle(HALTED, 16'd0);
        step(2, "midrd_hold");
        Reset = 1'b1;
        step(2, "midrd_release");
    endtask

    task automatic test_sweep(input int d, input int mw);
        cur_dut = d;
        oe_low = 0;
        if (d == 1) bus_b.Run = 1'b0; else bus_c.Run = 1'b0;
        push_fetch(mw, 16'd0);
        rest = idle(PAUSE, 16'd1);
        step(mw + 4, "sweep_fetch");
        bus_b.Run = 1'b1; bus_c.Run = 1'b1;
        step(1, "sweep_pause");
        vectors++;
        if (oe_low !== mw) begin
            miscompares++;
            $display("FAIL sweep_oe_cycles mw=%0d: got %0d want %0d", mw, oe_low, mw);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; cur_dut = 0; oe_low = 0;
        Reset = 1'b1;
        bus_a.Run = 1'b1; bus_a.Continue = 1'b1;
        bus_b.Run = 1'b1; bus_b.Continue = 1'b1;
        bus_c.Run = 1'b1; bus_c.Continue = 1'b1;
        test_reset();
        test_fetch_timing();
        test_held_continue();
        test_dropped_presses();
        test_reset_mid_read();
        test_sweep(1, 1);
        test_sweep(2, 5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/slc3_fetch_ctrl.md
Name: slc3_fetch_ctrl

Overview:
- Control unit that sequences the SLC-3 fetch datapath (PC, MAR, MDR, IR, tri-state bus gates) and the external SRAM strobes.
- Runs the fetch loop MAR<-PC / PC<-PC+1, then MDR<-M[MAR], then IR<-MDR, then pauses for the operator.
- Starts on a Run press and resumes on each Continue press.
- Counts fetched instructions for display.

Parameters:
MEM_WAIT, 2, number of cycles the SRAM read strobes are held (1..15); MDR loads on the last one.
CNT_W, 16, width of the fetched-instruction counter.

Ports:
Clk  input  1  system clock, all state on rising edge
Reset  input  1  asynchronous, active-low reset
Run  input  1  active-low pushbutton (pre-debounced); a press starts execution
Continue  input  1  active-low pushbutton (pre-debounced); a press leaves PAUSE
load_mar  output  1  MAR load enable
load_pc  output  1  PC load enable (PC input is PC+1)
load_mdr  output  1  MDR load enable
load_ir  output  1  IR load enable
gate_pc  output  1  drives PC onto the bus
gate_mdr  output  1  drives MDR onto the bus
mio_en  output  1  MDR input mux select: 1 = SRAM Data, 0 = bus
CE, UB, LB, OE, WE  output  1 each  SRAM strobes, active-low
state_dbg  output  3  encoded current state (ctrl_state_t)
inst_count  output  CNT_W  number of IR loads since reset

Behaviour:
- Reset (asserted low, async):
  - state = HALTED; wait counter = 0; inst_count = 0; button history regs = 1.
  - All load/gate/mio_en outputs = 0; CE/UB/LB/OE/WE = 1.
  - Outputs are decoded from state, so all of these values hold immediately, including when reset hits mid-read.
- Press detect: registered prev value per button. A press is a one-cycle pulse when prev = 1 and current = 0. Holding a button low produces exactly one press. Presses arriving in a state that does not consume them are dropped, not latched.
- HALTED: all outputs idle. Run press -> FETCH1. If Run and Continue are pressed in the same cycle, Run wins.
- FETCH1 (1 cycle): gate_pc = load_mar = load_pc = 1 -> MEM_RD. Clear wait counter.
- MEM_RD (MEM_WAIT cycles): CE = UB = LB = OE = 0, WE = 1, mio_en = 1, counter increments each cycle. On the cycle where counter = MEM_WAIT-1: load_mdr = 1, next state FETCH3.
- FETCH3 (1 cycle): gate_mdr = load_ir = 1; inst_count += 1, wrapping modulo 2^CNT_W -> PAUSE.
- PAUSE: idle outputs. Continue press -> FETCH1. Run press is ignored.
- Fetch latency: Run press to load_ir = MEM_WAIT+2 cycles after the FETCH1 entry edge.
- Invariants:
  - gate_pc and gate_mdr are never both 1.
  - WE is never 0; this block issues no writes.
  - OE = 0 only in MEM_RD.
  - Unreachable state encodings recover to HALTED.
- Each output is a pure function of state (and counter, for load_mdr). No combinational path from Run or Continue to outputs.

Decomposition:
- lc3b_types gains:
  - enum ctrl_state_t {HALTED, FETCH1, MEM_RD, FETCH3, PAUSE}, 3-bit.
  - constant MEM_WAIT_DEFAULT = 2.
- One sub-module, button_press: async active-low reset, outputs a single-cycle press pulse. Instantiated twice (Run, Continue).
- Rest is one FSM: state register + wait counter + output decode.

Test Plan:
- Reset: hold Reset = 0 for 3 cycles with Run = 0 -> state_dbg = HALTED, all loads/gates 0, CE..WE = 1, inst_count = 0. Releasing with Run already low produces no start.
- Fetch timing (MEM_WAIT = 2): Run 1->0 at cycle 0.
  - Cycle 1: FETCH1, gate_pc = load_mar = load_pc = 1.
  - Cycles 2-3: OE = CE = 0; load_mdr = 1 only in cycle 3.
  - Cycle 4: load_ir = gate_mdr = 1.
  - Cycle 5: PAUSE, inst_count = 1.
- Held Continue: press Continue and hold low 20 cycles -> exactly one fetch, inst_count = 2, stays in PAUSE. Release then press again -> inst_count = 3.
- Dropped presses: Continue pulsed during MEM_RD and Run pulsed in PAUSE -> no state change; still PAUSE after fetch completes.
- Reset mid-read: assert Reset in the second MEM_RD cycle -> OE/CE return to 1 in the same cycle without a clock edge, state = HALTED, inst_count = 0.
- Parameter sweep MEM_WAIT = 1 and 5: OE low for exactly 1 / 5 cycles. load_mdr is high only in the final low-OE cycle. Checker asserts gate exclusivity and WE = 1 throughout.
